onehot_rx_fifo: RTL and testbench

Receive stage directly downstream of `enc_bin2onehot`. It validates and encodes each 15-bit one-hot code back to a 4-bit index, then buffers accepted codes in a small FIFO. The consumer drains the FIFO with a valid/ready handshake. The upstream encoder has no back-pressure, so this block also detects illegal codes and overflow drops and reports them as sticky flags.

---
 rtl/onehot_rx_fifo.sv | 134 +++++++++++++
 tb/tb_onehot_rx_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/onehot_rx_fifo.sv
// Receive stage for one-hot codes: validates/encodes each 15-bit code to a 4-bit index,
// buffers it in a DEPTH-entry FIFO, and flags illegal codes (err) and overflow drops (ovf).
// Optional event counter err_cnt is compiled in when ONEHOT_ERR_CNT_EN is defined.
module onehot_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] in,
    input  logic        err_clr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out,
    output logic        err,
    output logic        ovf
`ifdef ONEHOT_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]    mem_reg [DEPTH];
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic          err_reg, err_next;
    logic          ovf_reg, ovf_next;

    logic [3:0] code_idx;
    logic       code_any, code_single, code_legal, code_illegal;
    logic       full, pop, push, drop;

    // Index bit gi is the OR of every input line whose position has bit gi set.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_enc
            logic [14:0] mask;
            for (genvar gk = 0; gk < 15; gk++) begin : g_mask
                assign mask[gk] = 1'(gk >> gi);
            end
            assign code_idx[gi] = |(in & mask);
        end
    endgenerate

    assign code_any     = (in != 15'd0);
    assign code_single  = ((in & (in - 15'd1)) == 15'd0);
    assign code_legal   = code_any && code_single;
    assign code_illegal = code_any && !code_single;

    assign full = (count_reg == (AW+1)'(DEPTH));
    assign pop  = out_valid && out_ready;
    assign push = code_legal && (!full || pop);
    assign drop = code_legal && full && !pop;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (push && !pop) begin
            count_next = count_reg + (AW+1)'(1);
        end else if (pop && !push) begin
            count_next = count_reg - (AW+1)'(1);
        end
        // Set wins over clear when both happen in the same cycle.
        err_next = code_illegal || (err_reg && !err_clr);
        ovf_next = drop || (ovf_reg && !err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            err_reg    <= err_next;
            ovf_reg    <= ovf_next;
        end
    end

    // Storage has no reset; emptiness is tracked by count_reg alone.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_reg[wr_ptr_reg] <= code_idx;
        end
    end

    assign out_valid = (count_reg != '0);
    assign out       = out_valid ? mem_reg[rd_ptr_reg] : 4'd0;
    assign err       = err_reg;
    assign ovf       = ovf_reg;

`ifdef ONEHOT_ERR_CNT_EN
    logic [7:0] err_cnt_reg, err_cnt_next;
    logic       cnt_event;

    assign cnt_event = code_illegal || drop;

    always_comb begin
        err_cnt_next = err_cnt_reg;
        if (cnt_event) begin
            if (err_clr) begin
                err_cnt_next = 8'd1;
            end else if (err_cnt_reg != 8'hFF) begin
                err_cnt_next = err_cnt_reg + 8'd1;
            end
        end else if (err_clr) begin
            err_cnt_next = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg <= 8'd0;
        end else begin
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_onehot_rx_fifo.sv
// Randomized + directed bench for onehot_rx_fifo against a queue-based reference model.
// Also exercises err_cnt when ONEHOT_ERR_CNT_EN is defined.
module tb_onehot_rx_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] in_code = 15'd0;
    logic        err_clr = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [3:0]  out_idx;
    logic        err;
    logic        ovf;
`ifdef ONEHOT_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    onehot_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_code),
        .err_clr   (err_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_idx),
        .err       (err),
        .ovf       (ovf)
`ifdef ONEHOT_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: FIFO as a queue of indices plus sticky state.
    int q[$];
    bit m_err = 1'b0;
    bit m_ovf = 1'b0;
    int m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic [14:0] c, input bit rdy, input bit clr, input bit r);
        int  ones;
        int  idx;
        bit  pop;
        bit  full;
        bit  dropped;
        if (r) begin
            q.delete();
            m_err = 1'b0;
            m_ovf = 1'b0;
            m_cnt = 0;
            return;
        end
        ones = $countones(c);
        idx = 0;
        for (int k = 0; k < 15; k++) if (c[k]) idx = k;
        pop  = (q.size() != 0) && rdy;
        full = (q.size() == DEPTH);
        dropped = 1'b0;
        if (pop) void'(q.pop_front());
        if (ones == 1) begin
            if (!full || pop) q.push_back(idx);
            else dropped = 1'b1;
        end
        m_err = (ones > 1) || (m_err && !clr);
        m_ovf = dropped || (m_ovf && !clr);
        if ((ones > 1) || dropped) m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        else if (clr) m_cnt = 0;
    endtask

    task automatic step(input logic [14:0] c, input bit rdy, input bit clr, input bit r);
        int exp_out;
        @(negedge clk);
        in_code   = c;
        out_ready = rdy;
        err_clr   = clr;
        rst       = r;
        @(posedge clk);
        model_update(c, rdy, clr, r);
        #1;
        exp_out = (q.size() != 0) ? q[0] : 0;
        $display("t=%0t rst=%0d in=%04h rdy=%0d clr=%0d -> valid=%0d out=%0d err=%0d ovf=%0d",
                 $time, r, c, rdy, clr, out_valid, out_idx, err, ovf);
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("out",       32'(out_idx),   32'(exp_out));
        check("err",       32'(err),       32'(m_err));
        check("ovf",       32'(ovf),       32'(m_ovf));
`ifdef ONEHOT_ERR_CNT_EN
        check("err_cnt",   32'(err_cnt),   32'(m_cnt));
`endif
    endtask

    function automatic logic [14:0] oh(input int k);
        logic [14:0] one;
        one = 15'd1;
        return one << k;
    endfunction

    initial begin
        // Reset, then a single code held until accepted
        step(15'h0000, 1'b0, 1'b0, 1'b1);
        step(15'h0000, 1'b0, 1'b0, 1'b1);
        step(15'h0008, 1'b0, 1'b0, 1'b0);
        repeat (3) step(15'h0000, 1'b0, 1'b0, 1'b0);
        step(15'h0000, 1'b1, 1'b0, 1'b0);

        // Fill, overflow, drain
        step(oh(0),  1'b0, 1'b0, 1'b0);
        step(oh(5),  1'b0, 1'b0, 1'b0);
        step(oh(9),  1'b0, 1'b0, 1'b0);
        step(oh(14), 1'b0, 1'b0, 1'b0);
        step(oh(7),  1'b0, 1'b0, 1'b0);
        repeat (5) step(15'h0000, 1'b1, 1'b0, 1'b0);
        step(15'h0000, 1'b0, 1'b1, 1'b0);

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) step(oh(i + 10), 1'b0, 1'b0, 1'b0);
        step(oh(2), 1'b1, 1'b0, 1'b0);
        repeat (5) step(15'h0000, 1'b1, 1'b0, 1'b0);

        // Illegal codes and clear priority
        step(15'h0011, 1'b0, 1'b0, 1'b0);
        step(15'h0000, 1'b0, 1'b1, 1'b0);
        step(15'h0011, 1'b0, 1'b0, 1'b0);
        step(15'h0011, 1'b0, 1'b1, 1'b0);
        step(15'h0000, 1'b0, 1'b1, 1'b0);

        // Streaming through pointer wrap
        for (int i = 0; i < 20; i++) step(oh(i % 15), 1'b1, 1'b0, 1'b0);
        step(15'h0000, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation, with an input present during reset
        for (int i = 0; i < 3; i++) step(oh(i + 1), 1'b0, 1'b0, 1'b0);
        step(oh(4), 1'b0, 1'b0, 1'b1);
        step(oh(6), 1'b0, 1'b0, 1'b0);
        step(oh(11), 1'b0, 1'b0, 1'b0);
        repeat (3) step(15'h0000, 1'b1, 1'b0, 1'b0);

`ifdef ONEHOT_ERR_CNT_EN
        // Saturation of the event counter
        repeat (260) step(15'h0003, 1'b0, 1'b0, 1'b0);
        step(15'h0000, 1'b0, 1'b1, 1'b0);
`endif

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [14:0] c;
            int sel, a, b;
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                c = 15'h0000;
            end else if (sel < 9) begin
                c = oh($urandom_range(0, 14));
            end else begin
                a = $urandom_range(0, 14);
                b = (a + 1 + $urandom_range(0, 13)) % 15;
                c = oh(a) | oh(b);
            end
            step(c, ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
